huffman_translation_scheduler: RTL and testbench
================================================

HUFFMAN_TRANSLATION_SCHEDULER -- requirements
Module: huffman_translation_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one huffman_translation instance.
REQ-002 Parameter LAT, default 3: cycles from translator enable to translator output_ready.
REQ-003 Parameter FIFO_DEPTH, default 8 (power of 2, >= LAT): response buffer entries.
REQ-004 The clock port SHALL be clk (input, 1): the single clock, rising edge.
REQ-005 The reset port SHALL be reset (input, 1): asynchronous, active-low reset.
REQ-006 req_valid (input, NUM_REQ): per-requester request pending.
REQ-007 req_ready (output, NUM_REQ): one-hot grant; request accepted when req_valid[i] and req_ready[i] are both high.
REQ-008 req_l (input, NUM_REQ*8): per-requester literal/length value, lane i at bits [8i+7:8i].
REQ-009 req_d (input, NUM_REQ*16): per-requester distance, 0 = literal.
REQ-010 tr_enable (output, 1): translator enable.
REQ-011 tr_l_V (output, 8) and tr_d_V (output, 16): translator operands.
REQ-012 tr_output_ready (input, 1): translator result valid.
REQ-013 tr_result (input, 56): {l_huffman_len[3:0], l_huffman_code[11:0], l_extra_len[3:0], l_extra[7:0], d_huffman_len[2:0], d_huffman_code[4:0], d_extra_len[3:0], d_extra[15:0]}, MSB first.
REQ-014 rsp_valid (output, 1), rsp_ready (input, 1): result handshake toward the bit packer.
REQ-015 rsp_id (output, clog2(NUM_REQ)) and rsp_data (output, 56): source requester and tr_result copy.
REQ-016 flush (input, 1), flush_done (output, 1, pulse), busy (output, 1).

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and DRAIN.
- IDLE -> ISSUE: any req_valid high and flush low.
- ISSUE -> IDLE: no req_valid high.
- IDLE/ISSUE -> DRAIN: flush high.
- DRAIN -> IDLE: occupancy reaches 0, with flush_done pulsing high for exactly one cycle.
REQ-018 Occupancy SHALL equal in-flight count plus FIFO count, with width clog2(FIFO_DEPTH)+1.
REQ-019 Issue SHALL occur only when occupancy < FIFO_DEPTH, flush is low, and the state is not DRAIN; it is evaluated combinationally in IDLE or ISSUE.
REQ-020 At most one issue SHALL occur per cycle. tr_enable, tr_l_V and tr_d_V are registered, so they appear one cycle after the accept.
REQ-021 Arbitration SHALL be round-robin. Priority starts at the requester after the last granted one and wraps from NUM_REQ-1 to 0. The pointer updates only on an accept.
REQ-022 req_ready SHALL be zero when issue is not allowed.
REQ-023 When no issue occurs, tr_enable SHALL be 0 and tr_l_V/tr_d_V SHALL hold their previous values.
REQ-024 A LAT-deep tag pipeline SHALL carry {valid, id} aligned with tr_enable.
REQ-025 When tr_output_ready is high, {tag id, tr_result} SHALL be pushed into the FIFO.
REQ-026 tr_output_ready high while the tag valid bit is 0 SHALL set sticky internal error bit tag_err (checked by the bench, no port).
REQ-027 The FIFO SHALL be first-word fall-through: rsp_valid = FIFO non-empty, and the head appears on rsp_id/rsp_data.
REQ-028 A pop occurs when rsp_valid and rsp_ready are both high. Push and pop in the same cycle leave the FIFO count unchanged.
REQ-029 An accept and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-030 Responses SHALL emerge in accept order, with no reordering and no drop.
REQ-031 Accept-to-rsp_valid latency SHALL be LAT+1 cycles on an empty FIFO: 1 issue register plus LAT.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra MSB distinguishing full from empty.
REQ-033 busy SHALL be high when state != IDLE or occupancy != 0.
REQ-034 A flush that arrives in the same cycle as req_valid SHALL produce no grant that cycle.

Reset
REQ-035 While reset is low, all of the following SHALL hold: state IDLE; pointer giving requester 0 highest priority; occupancy 0; FIFO empty; tag pipeline invalid; tag_err 0.
REQ-036 While reset is low, all outputs SHALL be 0: req_ready, tr_enable, tr_l_V, tr_d_V, rsp_valid, rsp_id, rsp_data, flush_done, busy.
REQ-037 A reset assertion mid-operation SHALL discard all in-flight and buffered results immediately. tr_output_ready pulses arriving after release with invalid tags are ignored (not pushed) and set tag_err.

Verification
REQ-038 Single request: req_valid=4'b0100, l=8'h41, d=0, rsp_ready=1 -> req_ready=4'b0100 in cycle 0; tr_enable in cycle 1 with tr_l_V=8'h41, tr_d_V=0; rsp_valid in cycle 4 with rsp_id=2.
REQ-039 Round-robin: all four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; one tr_enable per cycle.
REQ-040 Backpressure: rsp_ready=0 with all requests valid -> exactly 8 accepts, then req_ready=0. After rsp_ready=1: 8 responses with ids 0,1,2,3,0,1,2,3, then issuing resumes.
REQ-041 Occupancy boundary: occupancy=7 with a pop and an accept in the same cycle -> occupancy stays 7 and req_ready remains available the next cycle. At occupancy=8 with a pop -> no accept that cycle, accept next cycle.
REQ-042 Flush: flush pulsed with 3 results in flight -> no further grants; flush_done pulses once after the third pop; state returns to IDLE; busy falls.
REQ-043 Reset mid-stream: reset low for 2 cycles with 5 results buffered -> rsp_valid=0, busy=0, tag_err=0 after release. A fresh request then completes with LAT+1 latency.

Source files
------------

// File: rtl/huffman_translation_scheduler.sv
// Round-robin scheduler sharing one fixed-latency huffman translator between
// NUM_REQ requesters. Accepted operands are registered into the translator,
// a tag pipeline remembers which requester each result belongs to, and
// results are buffered in a first-word-fall-through FIFO toward the packer.
// Occupancy (in flight + buffered) gates issue so the FIFO can never overflow.
module huffman_translation_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [NUM_REQ-1:0]                                req_valid,
    output logic [NUM_REQ-1:0]                                req_ready,
    input  logic [NUM_REQ*8-1:0]                              req_l,
    input  logic [NUM_REQ*16-1:0]                             req_d,
    output logic                                              tr_enable,
    output logic [7:0]                                        tr_l_V,
    output logic [15:0]                                       tr_d_V,
    input  logic                                              tr_output_ready,
    input  logic [55:0]                                       tr_result,
    output logic                                              rsp_valid,
    input  logic                                              rsp_ready,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
    output logic [55:0]                                       rsp_data,
    input  logic                                              flush,
    output logic                                              flush_done,
    output logic                                              busy
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = ID_W + 56;
    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [OCC_W-1:0]   inflight_cnt;
    logic [OCC_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   fifo_cnt;
    logic [OCC_W-1:0]   occupancy;
    logic [OCC_W-1:0]   occupancy_next;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [ENT_W-1:0]   fifo_head;
    logic [LAT-1:0]     tag_valid;
    logic [ID_W-1:0]    tag_id [LAT];
    logic               tag_err;

    logic               any_req;
    logic               issue_ok;
    logic               accept;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic               push;
    logic               pop;
    logic [7:0]         lane_l [NUM_REQ];
    logic [15:0]        lane_d [NUM_REQ];

    // Split the flat operand buses into per-lane views and build the one-hot grant.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_l[gi]    = req_l[gi*8 +: 8];
        assign lane_d[gi]    = req_d[gi*16 +: 16];
        assign req_ready[gi] = accept && (grant_id == ID_W'(gi));
    end

    // Round-robin search: first valid requester at or after the priority pointer.
    always_comb begin
        logic [ID_W:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end

    // Reset gates issue so no grant leaks out while the block is held in reset.
    assign any_req        = |req_valid;
    assign issue_ok       = reset && (state != DRAIN) && !flush &&
                            (occupancy < OCC_W'(FIFO_DEPTH));
    assign accept         = issue_ok && grant_found;
    assign push           = tr_output_ready && tag_valid[LAT-1];
    assign fifo_cnt       = wr_ptr - rd_ptr;
    assign occupancy      = inflight_cnt + fifo_cnt;
    assign occupancy_next = occupancy + OCC_W'(accept) - OCC_W'(pop);
    assign fifo_head      = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign rsp_valid      = (fifo_cnt != '0);
    assign pop            = rsp_valid && rsp_ready;
    assign rsp_id         = rsp_valid ? fifo_head[ENT_W-1 -: ID_W] : '0;
    assign rsp_data       = rsp_valid ? fifo_head[55:0] : '0;
    assign busy           = (state != IDLE) || (occupancy != '0);

    // Issue register toward the translator plus round-robin pointer advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tr_enable <= 1'b0;
            tr_l_V    <= '0;
            tr_d_V    <= '0;
            rr_ptr    <= '0;
        end else begin
            tr_enable <= accept;
            if (accept) begin
                tr_l_V <= lane_l[grant_id];
                tr_d_V <= lane_d[grant_id];
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Tag pipeline aligned with tr_enable; its last stage pairs with tr_output_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
            tag_err      <= 1'b0;
            inflight_cnt <= '0;
        end else begin
            tag_valid[0] <= accept;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            // A result with no matching tag is dropped and remembered.
            if (tr_output_ready && !tag_valid[LAT-1]) begin
                tag_err <= 1'b1;
            end
            inflight_cnt <= inflight_cnt + OCC_W'(accept) - OCC_W'(push);
        end
    end

    // Response FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {tag_id[LAT-1], tr_result};
        end
    end

    // FIFO pointers with an extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Control FSM: issue while requests exist, drain everything on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (any_req) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (!any_req) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (occupancy_next == '0) begin
                        state      <= IDLE;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_translation_scheduler.sv
// Bench for huffman_translation_scheduler: a fixed-latency translator model,
// a transaction-level reference (queues of accepted requests with due cycles)
// compared every cycle, and directed scenarios with hand-computed literals.
module tb_huffman_translation_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LAT     = 3;
    localparam int DEPTH   = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [31:0]  req_l;
    logic [63:0]  req_d;
    logic         tr_enable;
    logic [7:0]   tr_l_V;
    logic [15:0]  tr_d_V;
    logic         tr_output_ready;
    logic [55:0]  tr_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [55:0]  rsp_data;
    logic         flush;
    logic         flush_done;
    logic         busy;

    always #5 clk = ~clk;

    huffman_translation_scheduler #(
        .NUM_REQ(NUM_REQ), .LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_l(req_l), .req_d(req_d),
        .tr_enable(tr_enable), .tr_l_V(tr_l_V), .tr_d_V(tr_d_V),
        .tr_output_ready(tr_output_ready), .tr_result(tr_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .flush(flush), .flush_done(flush_done), .busy(busy)
    );

    // Stand-in translation: any distinct, operand-dependent 56-bit value.
    function automatic logic [55:0] xlate(logic [7:0] l, logic [15:0] d);
        return {d, l, 8'h5A, d ^ 16'hBEEF, l ^ 8'h3C};
    endfunction

    // Translator model: result is presented LAT-1 cycles after the enable cycle.
    typedef struct { bit v; logic [7:0] l; logic [15:0] d; } op_t;
    op_t pipe [LAT];
    bit  inject = 1'b0;

    initial begin
        tr_output_ready = 1'b0;
        tr_result       = '0;
        for (int k = 0; k < LAT; k++) begin
            pipe[k].v = 1'b0; pipe[k].l = '0; pipe[k].d = '0;
        end
    end

    always @(negedge clk) begin
        #1;
        for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0].v = tr_enable;
        pipe[0].l = tr_l_V;
        pipe[0].d = tr_d_V;
        tr_output_ready = pipe[LAT-1].v || inject;
        tr_result       = pipe[LAT-1].v ? xlate(pipe[LAT-1].l, pipe[LAT-1].d) : 56'h0;
        inject          = 1'b0;
    end

    // Reference model state.
    typedef struct { int id; logic [7:0] l; logic [15:0] d; int due; } txn_t;
    txn_t        flight [$];
    txn_t        rspq   [$];
    int          cyc = 0;
    int          next_pri, occ;
    bit          drain, active, fd_pend, exp_en;
    logic [7:0]  exp_l;
    logic [15:0] exp_d;
    int          g_cur;
    bit          pop_cur;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic model_clear();
        flight.delete(); rspq.delete();
        next_pri = 0; occ = 0; drain = 0; active = 0; fd_pend = 0;
        exp_en = 0; exp_l = '0; exp_d = '0;
    endtask

    // Compare all outputs of the current cycle against the model.
    task automatic settle();
        logic [3:0] er;
        int g;
        #3;
        while (flight.size() > 0 && flight[0].due <= cyc) rspq.push_back(flight.pop_front());
        er = '0; g = -1;
        if (!drain && !flush && occ < DEPTH) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (next_pri + k) % NUM_REQ;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("tr_enable", tr_enable, exp_en);
        chk("tr_l_V", tr_l_V, exp_l);
        chk("tr_d_V", tr_d_V, exp_d);
        chk("rsp_valid", rsp_valid, rspq.size() > 0);
        if (rspq.size() > 0) begin
            chk("rsp_id", rsp_id, rspq[0].id);
            chk("rsp_data", rsp_data, xlate(rspq[0].l, rspq[0].d));
        end
        chk("busy", busy, drain || active || occ != 0);
        chk("flush_done", flush_done, fd_pend);
        g_cur   = g;
        pop_cur = (rspq.size() > 0) && rsp_ready;
    endtask

    // Apply the cycle's accept/pop/state effects, then move to the next cycle.
    task automatic adv();
        txn_t t;
        if (g_cur >= 0) begin
            t.id = g_cur; t.l = req_l[g_cur*8 +: 8]; t.d = req_d[g_cur*16 +: 16];
            t.due = cyc + LAT + 1;
            flight.push_back(t);
            next_pri = (g_cur + 1) % NUM_REQ;
            occ++;
            exp_en = 1; exp_l = t.l; exp_d = t.d;
        end else begin
            exp_en = 0;
        end
        if (pop_cur) begin
            void'(rspq.pop_front());
            occ--;
        end
        fd_pend = 0;
        if (drain) begin
            if (occ == 0) begin drain = 0; fd_pend = 1; active = 0; end
        end else if (flush) begin
            drain = 1; active = 0;
        end else begin
            active = |req_valid;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(int n);
        reset = 1'b0;
        model_clear();
        repeat (n) begin
            #3;
            chk("reset_outputs", {req_ready, tr_enable, tr_l_V, tr_d_V, rsp_valid, rsp_id, flush_done, busy}, 64'h0);
            chk("reset_rsp_data", rsp_data, 64'h0);
            chk("reset_tag_err", dut.tag_err, 64'h0);
            cyc++;
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    task automatic wait_idle(string name);
        bit done;
        done = 0;
        for (int n = 0; n < 40; n++) begin
            settle();
            done = !busy;
            adv();
            if (done) break;
        end
        chk(name, done, 64'h1);
    endtask

    initial begin
        int         acc, pops, fdc, lat;
        bit         found, last_busy;
        logic [1:0] ids [8];

        reset     = 1'b0;
        req_valid = 4'b1111;
        req_l     = {8'hD3, 8'h41, 8'hB1, 8'hA0};
        req_d     = {16'h0103, 16'h0000, 16'h0101, 16'h0100};
        rsp_ready = 1'b1;
        flush     = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset(2);

        // Round robin with all requesters valid.
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k < 6) chk("rr_grant", req_ready, 64'(4'b0001 << (k % 4)));
            if (k >= 1) chk("rr_tr_enable", tr_enable, 64'h1);
            adv();
        end
        req_valid = 4'b0000;
        wait_idle("rr_idle");

        // Backpressure: exactly DEPTH accepts, then stall until responses drain.
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (req_ready != 0) acc++;
            if (k == 11) chk("bp_stalled", req_ready, 64'h0);
            adv();
        end
        chk("bp_accepts", acc, 64'd8);
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            ids[k] = rsp_id;
            if (k == 0) chk("full_pop_no_grant", req_ready, 64'h0);
            if (k == 1 || k == 2) begin
                chk("occ7_grant", req_ready != 0, 64'h1);
                chk("occ7_value", dut.occupancy, 64'd7);
            end
            adv();
        end
        for (int k = 0; k < 8; k++) chk("bp_order", ids[k], 64'(k % 4));
        req_valid = 4'b0000;
        wait_idle("bp_idle");

        // Single request from requester 2.
        req_valid = 4'b0100;
        settle(); chk("single_grant", req_ready, 64'h4); adv();
        req_valid = 4'b0000;
        settle();
        chk("single_en", tr_enable, 64'h1);
        chk("single_l", tr_l_V, 64'h41);
        chk("single_d", tr_d_V, 64'h0);
        adv();
        for (int k = 2; k < 4; k++) begin
            settle(); chk("single_early", rsp_valid, 64'h0); adv();
        end
        settle();
        chk("single_valid", rsp_valid, 64'h1);
        chk("single_id", rsp_id, 64'h2);
        chk("single_data", rsp_data, 64'h0000_415A_BEEF_7D);
        adv();
        wait_idle("single_idle");

        // Flush with three results in flight; requests stay up briefly to prove no grant.
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin settle(); adv(); end
        flush = 1'b1;
        settle(); chk("flush_no_grant", req_ready, 64'h0); adv();
        flush = 1'b0;
        pops = 0; fdc = 0; last_busy = 1'b1;
        for (int j = 0; j < 10; j++) begin
            req_valid = (j < 2) ? 4'b1111 : 4'b0000;
            settle();
            if (j < 2) chk("drain_no_grant", req_ready, 64'h0);
            if (flush_done) begin
                fdc++;
                chk("fd_after_pops", pops, 64'd3);
            end
            if (rsp_valid && rsp_ready) pops++;
            last_busy = busy;
            adv();
        end
        chk("fd_count", fdc, 64'd1);
        chk("flush_busy_low", last_busy, 64'h0);

        // Reset with five results buffered.
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin settle(); adv(); end
        req_valid = 4'b0000;
        for (int k = 0; k < 5; k++) begin settle(); adv(); end
        chk("buffered_five", dut.occupancy, 64'd5);
        req_valid = 4'b0001;
        do_reset(2);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        settle();
        chk("post_reset_rsp_valid", rsp_valid, 64'h0);
        chk("post_reset_busy", busy, 64'h0);
        chk("post_reset_tag_err", dut.tag_err, 64'h0);
        adv();
        req_valid = 4'b1000;
        settle(); chk("fresh_grant", req_ready, 64'h8); adv();
        req_valid = 4'b0000;
        found = 0; lat = 0;
        for (int k = 1; k <= 10 && !found; k++) begin
            settle();
            if (rsp_valid) begin
                found = 1; lat = k;
                chk("fresh_id", rsp_id, 64'h3);
            end
            adv();
        end
        chk("fresh_latency", lat, 64'(LAT + 1));
        wait_idle("fresh_idle");

        // A translator result with no tag behind it must be dropped and flagged.
        chk("tag_err_clear", dut.tag_err, 64'h0);
        inject = 1'b1;
        settle(); adv();
        settle();
        chk("tag_err_set", dut.tag_err, 64'h1);
        chk("spurious_not_pushed", rsp_valid, 64'h0);
        adv();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
